interrupt_controller: RTL and testbench
=======================================

INTERRUPT_CONTROLLER -- requirements
Module: interrupt_controller

Interface
REQ-001 SHALL have parameter NSRC, default 8, meaning number of interrupt source lines (legal range 1..16).
REQ-002 SHALL have port clk  input  1  sole clock, all state on posedge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port IntSrc  input  NSRC  raw asynchronous peripheral interrupt lines, active-high.
REQ-005 SHALL have port RegWE  input  1  register write strobe, one write per cycle.
REQ-006 SHALL have port RegAddr  input  3  word register index.
REQ-007 SHALL have port RegWData  input  32  write data.
REQ-008 SHALL have port RegRData  output  32  combinational read data for RegAddr.
REQ-009 SHALL have ports IRQAssert and FIQAssert  input  1 each  exception-entry acknowledges from the exception handler.
REQ-010 SHALL have ports IRQ and FIQ  output  1 each  registered interrupt requests to the exception handler.

Function
REQ-011 Each IntSrc bit SHALL pass a 2-flop synchronizer; a third flop holds the previous synchronized value for edge detection.
REQ-012 Registers: 0 RAW (RO, synchronized levels); 1 ENABLE (RW); 2 FIQSEL (RW, 1=route to FIQ); 3 EDGE (RW, 1=rising-edge, 0=level); 4 PEND (R, W1C); 5 IRQID (RO); 6 FIQID (RO); 7 reads 0, writes ignored.
REQ-013 Bits above NSRC SHALL read 0 and ignore writes.
REQ-014 Edge mode: PEND bit SHALL set on the cycle sync=1 and prev=0, and stay set until cleared by W1C.
REQ-015 Edge mode, set and W1C in the same cycle: set SHALL win.
REQ-016 Level mode: PEND bit SHALL equal the synchronized level; W1C has no effect.
REQ-017 Changing a bit from edge to level mode SHALL make PEND track the level from the next cycle.
REQ-018 Changing a bit from level to edge mode SHALL clear PEND on the write cycle.
REQ-019 PEND SHALL set regardless of ENABLE.
REQ-020 Next IRQ SHALL be OR(PEND & ENABLE & ~FIQSEL).
REQ-021 Next FIQ SHALL be OR(PEND & ENABLE & FIQSEL).
REQ-022 IRQ and FIQ SHALL both be registered.
REQ-023 Latency: an IntSrc rise sampled at posedge k SHALL give PEND at k+2 and IRQ/FIQ high after posedge k+3.
REQ-024 On IRQAssert, IRQID SHALL capture {valid=1 in bit 31, lowest-index source in PEND&ENABLE&~FIQSEL in bits 3:0}.
REQ-025 FIQID SHALL capture likewise on FIQAssert, using the FIQSEL term.
REQ-026 If no source is active at acknowledge, IRQID/FIQID SHALL capture valid=0, index 0.
REQ-027 Reading IRQID or FIQID SHALL have no side effects.
REQ-028 Simultaneous IRQAssert and FIQAssert SHALL update both ID registers.
REQ-029 A register write SHALL take effect at the next posedge; its influence on IRQ/FIQ SHALL appear one cycle later (registered output).

Reset
REQ-030 Reset SHALL clear, asynchronously: synchronizers, prev flops, ENABLE, FIQSEL, EDGE, PEND, IRQID, FIQID, IRQ and FIQ.
REQ-031 After reset, IRQ=FIQ=0 and RegRData=0 for every address.
REQ-032 Reset asserted mid-operation SHALL drop IRQ/FIQ in the same cycle.
REQ-033 An edge in progress through the synchronizer during reset SHALL be lost.
REQ-034 After release, a level still high in EDGE mode SHALL NOT create a pending edge, because EDGE resets to 0 (level mode).

Structure
REQ-035 Register address constants and the IDVALID bit position SHALL live in a shared package (leg_intc_pkg).
REQ-036 The lowest-index priority encoder SHALL be a sub-module, prio_encoder, parameterized on width.
REQ-037 The synchronizer SHALL reuse the codebase flopr primitive; no new flop primitive.

Verification
REQ-038 Bench SHALL cover: ENABLE=0x01, EDGE=0x01; pulse IntSrc[0] one cycle at posedge k -> PEND=0x01 at k+2, IRQ=1 after k+3, FIQ=0; W1C 0x01 -> IRQ=0 two cycles later.
REQ-039 Bench SHALL cover: level mode, ENABLE=0x80, FIQSEL=0x80, hold IntSrc[7] high -> FIQ=1; W1C PEND -> FIQ stays 1; drop line -> FIQ=0 four cycles later.
REQ-040 Bench SHALL cover: EDGE=0x04 with edge detected in the same cycle as W1C 0x04 -> PEND[2] remains 1.
REQ-041 Bench SHALL cover: PEND=0x0C, ENABLE=0x0C, FIQSEL=0, pulse IRQAssert -> IRQID=0x80000002.
REQ-042 Bench SHALL cover: same with ENABLE=0 -> IRQID=0x00000000 and IRQ=0.
REQ-043 Bench SHALL cover: IRQ=1, then reset asserted between clock edges -> IRQ=0 immediately, all registers read 0.

Source files
------------

// File: rtl/leg_intc_pkg.sv
// Shared definitions for the interrupt controller: register map, ID register layout
// and a helper that assembles an ID word.
package leg_intc_pkg;

  typedef enum logic [2:0] {
    REG_RAW    = 3'd0,
    REG_ENABLE = 3'd1,
    REG_FIQSEL = 3'd2,
    REG_EDGE   = 3'd3,
    REG_PEND   = 3'd4,
    REG_IRQID  = 3'd5,
    REG_FIQID  = 3'd6,
    REG_RSVD   = 3'd7
  } reg_addr_e;

  localparam int IDVALID_BIT = 31;
  localparam int ID_IDX_W    = 4;
  localparam int MAX_NSRC    = 16;

  // An ID word with no valid source is all zeros, index included.
  function automatic logic [31:0] make_id(input logic valid, input logic [ID_IDX_W-1:0] idx);
    logic [31:0] id;
    id = '0;
    if (valid) begin
      id[IDVALID_BIT]    = 1'b1;
      id[ID_IDX_W-1:0]   = idx;
    end
    return id;
  endfunction

endpackage

// File: rtl/flopr.sv
// Resettable D flip-flop bank, asynchronous active-high reset to zero.
module flopr #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) q <= '0;
    else       q <= d;
  end

endmodule

// File: rtl/prio_encoder.sv
// Lowest-index-wins priority encoder; o_idx is 0 when no request is present.
module prio_encoder #(
  parameter int WIDTH = 8,
  parameter int IDX_W = 4
) (
  input  logic [WIDTH-1:0] i_req,
  output logic             o_valid,
  output logic [IDX_W-1:0] o_idx
);

  always_comb begin
    o_valid = |i_req;
    o_idx   = '0;
    // Scanning downward lets the lowest set bit be the last assignment.
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (i_req[i]) o_idx = IDX_W'(i);
    end
  end

endmodule

// File: rtl/interrupt_controller.sv
// Interrupt controller: synchronizes raw source lines, latches edge/level pending bits,
// and routes enabled sources to registered IRQ/FIQ requests with acknowledge-time ID capture.
module interrupt_controller
  import leg_intc_pkg::*;
#(
  parameter int NSRC = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [NSRC-1:0] IntSrc,
  input  logic            RegWE,
  input  logic [2:0]      RegAddr,
  input  logic [31:0]     RegWData,
  output logic [31:0]     RegRData,
  input  logic            IRQAssert,
  input  logic            FIQAssert,
  output logic            IRQ,
  output logic            FIQ
);

  logic [NSRC-1:0] w_sync1;
  logic [NSRC-1:0] w_sync2;
  logic [NSRC-1:0] w_prev;
  logic [NSRC-1:0] w_rise;
  logic [NSRC-1:0] w_wdata;
  logic [NSRC-1:0] w_pend_next;
  logic [NSRC-1:0] w_irq_src;
  logic [NSRC-1:0] w_fiq_src;
  logic            w_wr_enable;
  logic            w_wr_fiqsel;
  logic            w_wr_edge;
  logic            w_wr_pend;
  logic            w_irq_valid;
  logic            w_fiq_valid;
  logic [ID_IDX_W-1:0] w_irq_idx;
  logic [ID_IDX_W-1:0] w_fiq_idx;
  logic            w_unused_wdata;

  logic [NSRC-1:0] r_enable;
  logic [NSRC-1:0] r_fiqsel;
  logic [NSRC-1:0] r_edge;
  logic [NSRC-1:0] r_pend;
  logic [31:0]     r_irqid;
  logic [31:0]     r_fiqid;
  logic            r_irq;
  logic            r_fiq;

  // Two-flop synchronizer plus a history flop for rising-edge detection.
  flopr #(.WIDTH(NSRC)) u_sync1 (.clk(clk), .reset(reset), .d(IntSrc),  .q(w_sync1));
  flopr #(.WIDTH(NSRC)) u_sync2 (.clk(clk), .reset(reset), .d(w_sync1), .q(w_sync2));
  flopr #(.WIDTH(NSRC)) u_prev  (.clk(clk), .reset(reset), .d(w_sync2), .q(w_prev));

  assign w_rise         = w_sync2 & ~w_prev;
  assign w_wdata        = RegWData[NSRC-1:0];
  assign w_unused_wdata = &{1'b0, RegWData[31:NSRC]};

  assign w_wr_enable = RegWE && (RegAddr == REG_ENABLE);
  assign w_wr_fiqsel = RegWE && (RegAddr == REG_FIQSEL);
  assign w_wr_edge   = RegWE && (RegAddr == REG_EDGE);
  assign w_wr_pend   = RegWE && (RegAddr == REG_PEND);

  // Level bits mirror the synchronized line (a switch to edge mode clears them);
  // edge bits are sticky, and a fresh edge beats a simultaneous write-1-to-clear.
  for (genvar gi = 0; gi < NSRC; gi++) begin : g_pend
    assign w_pend_next[gi] = !r_edge[gi]
                           ? ((w_wr_edge && w_wdata[gi]) ? 1'b0 : w_sync2[gi])
                           : (w_rise[gi] ? 1'b1
                              : ((w_wr_pend && w_wdata[gi]) ? 1'b0 : r_pend[gi]));
  end

  assign w_irq_src = r_pend & r_enable & ~r_fiqsel;
  assign w_fiq_src = r_pend & r_enable &  r_fiqsel;

  prio_encoder #(.WIDTH(NSRC), .IDX_W(ID_IDX_W)) u_irq_prio (
    .i_req   (w_irq_src),
    .o_valid (w_irq_valid),
    .o_idx   (w_irq_idx)
  );

  prio_encoder #(.WIDTH(NSRC), .IDX_W(ID_IDX_W)) u_fiq_prio (
    .i_req   (w_fiq_src),
    .o_valid (w_fiq_valid),
    .o_idx   (w_fiq_idx)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_enable <= '0;
      r_fiqsel <= '0;
      r_edge   <= '0;
      r_pend   <= '0;
      r_irqid  <= '0;
      r_fiqid  <= '0;
      r_irq    <= 1'b0;
      r_fiq    <= 1'b0;
    end else begin
      if (w_wr_enable) r_enable <= w_wdata;
      if (w_wr_fiqsel) r_fiqsel <= w_wdata;
      if (w_wr_edge)   r_edge   <= w_wdata;
      r_pend <= w_pend_next;
      r_irq  <= |w_irq_src;
      r_fiq  <= |w_fiq_src;
      if (IRQAssert) r_irqid <= make_id(w_irq_valid, w_irq_idx);
      if (FIQAssert) r_fiqid <= make_id(w_fiq_valid, w_fiq_idx);
    end
  end

  always_comb begin
    RegRData = '0;
    case (RegAddr)
      REG_RAW:    RegRData = 32'(w_sync2);
      REG_ENABLE: RegRData = 32'(r_enable);
      REG_FIQSEL: RegRData = 32'(r_fiqsel);
      REG_EDGE:   RegRData = 32'(r_edge);
      REG_PEND:   RegRData = 32'(r_pend);
      REG_IRQID:  RegRData = r_irqid;
      REG_FIQID:  RegRData = r_fiqid;
      default:    RegRData = '0;
    endcase
  end

  assign IRQ = r_irq;
  assign FIQ = r_fiq;

endmodule

// File: tb/tb_interrupt_controller.sv
// Directed scenarios followed by randomized traffic, checked against a cycle-level
// behavioural model of the controller's register and request rules.
module tb_interrupt_controller;

  localparam int N = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic [N-1:0]  IntSrc;
  logic          RegWE;
  logic [2:0]    RegAddr;
  logic [31:0]   RegWData;
  logic [31:0]   RegRData;
  logic          IRQAssert;
  logic          FIQAssert;
  logic          IRQ;
  logic          FIQ;

  int n_checks = 0;
  int n_fail   = 0;

  // Model state
  logic [N-1:0] m_en, m_fs, m_edge, m_pend;
  logic [31:0]  m_irqid, m_fiqid;
  logic         m_irq, m_fiq;
  logic [N-1:0] smp [3];   // smp[0] = IntSrc sampled at the latest edge, older behind it

  interrupt_controller #(.NSRC(N)) dut (
    .clk       (clk),
    .reset     (reset),
    .IntSrc    (IntSrc),
    .RegWE     (RegWE),
    .RegAddr   (RegAddr),
    .RegWData  (RegWData),
    .RegRData  (RegRData),
    .IRQAssert (IRQAssert),
    .FIQAssert (FIQAssert),
    .IRQ       (IRQ),
    .FIQ       (FIQ)
  );

  always #50 clk = ~clk;

  function automatic logic [31:0] id_of(input logic [N-1:0] v);
    for (int i = 0; i < N; i++) begin
      if (v[i]) return 32'h8000_0000 | 32'(i);
    end
    return 32'h0;
  endfunction

  function automatic logic [31:0] model_read(input logic [2:0] a);
    case (a)
      3'd0: return {24'h0, smp[1]};
      3'd1: return {24'h0, m_en};
      3'd2: return {24'h0, m_fs};
      3'd3: return {24'h0, m_edge};
      3'd4: return {24'h0, m_pend};
      3'd5: return m_irqid;
      3'd6: return m_fiqid;
      default: return 32'h0;
    endcase
  endfunction

  task automatic model_reset();
    m_en = '0; m_fs = '0; m_edge = '0; m_pend = '0;
    m_irqid = '0; m_fiqid = '0; m_irq = 1'b0; m_fiq = 1'b0;
    for (int i = 0; i < 3; i++) smp[i] = '0;
  endtask

  // One clock edge of the controller, from the inputs presented at that edge.
  task automatic model_update();
    logic [N-1:0] lvl, rise, wd, nxt, irq_src, fiq_src;
    lvl     = smp[1];
    rise    = smp[1] & ~smp[2];
    wd      = RegWData[N-1:0];
    irq_src = m_pend & m_en & ~m_fs;
    fiq_src = m_pend & m_en &  m_fs;
    for (int i = 0; i < N; i++) begin
      if (!m_edge[i])                             nxt[i] = (RegWE && RegAddr == 3'd3 && wd[i]) ? 1'b0 : lvl[i];
      else if (rise[i])                           nxt[i] = 1'b1;
      else if (RegWE && RegAddr == 3'd4 && wd[i]) nxt[i] = 1'b0;
      else                                        nxt[i] = m_pend[i];
    end
    if (IRQAssert) m_irqid = id_of(irq_src);
    if (FIQAssert) m_fiqid = id_of(fiq_src);
    m_irq = |irq_src;
    m_fiq = |fiq_src;
    if (RegWE) begin
      case (RegAddr)
        3'd1: m_en   = wd;
        3'd2: m_fs   = wd;
        3'd3: m_edge = wd;
        default: ;
      endcase
    end
    m_pend = nxt;
    smp[2] = smp[1];
    smp[1] = smp[0];
    smp[0] = IntSrc;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one clock; returns at the following falling edge.
  task automatic step();
    @(posedge clk);
    if (!reset) model_update();
    @(negedge clk);
  endtask

  task automatic rd(input string tag, input logic [2:0] a, input logic [31:0] exp);
    RegAddr = a;
    #1;
    chk(tag, RegRData, exp);
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    RegWE = 1'b1; RegAddr = a; RegWData = d;
    step();
    RegWE = 1'b0;
  endtask

  task automatic check_model(input string tag);
    chk({tag, "_irq"}, {31'h0, IRQ}, {31'h0, m_irq});
    chk({tag, "_fiq"}, {31'h0, FIQ}, {31'h0, m_fiq});
    for (int a = 0; a < 8; a++) rd($sformatf("%s_reg%0d", tag, a), 3'(a), model_read(3'(a)));
  endtask

  initial begin
    reset = 1'b1; IntSrc = '0; RegWE = 1'b0; RegAddr = '0; RegWData = '0;
    IRQAssert = 1'b0; FIQAssert = 1'b0;
    model_reset();
    @(negedge clk);
    step(); step();
    chk("rst_irq", {31'h0, IRQ}, 32'h0);
    chk("rst_fiq", {31'h0, FIQ}, 32'h0);
    for (int a = 0; a < 8; a++) rd($sformatf("rst_reg%0d", a), 3'(a), 32'h0);
    reset = 1'b0;

    // Edge-mode pulse on source 0 routed to IRQ, then cleared.
    wr(3'd1, 32'h01);
    wr(3'd3, 32'h01);
    IntSrc = 8'h01; step();            // posedge k samples the pulse
    IntSrc = 8'h00; step();            // k+1
    step();                            // k+2
    rd("edge_pend_k2", 3'd4, 32'h01);
    chk("edge_irq_k2", {31'h0, IRQ}, 32'h0);
    step();                            // k+3
    chk("edge_irq_k3", {31'h0, IRQ}, 32'h1);
    chk("edge_fiq_k3", {31'h0, FIQ}, 32'h0);
    wr(3'd4, 32'h01);
    chk("w1c_irq_1", {31'h0, IRQ}, 32'h1);
    step();
    chk("w1c_irq_2", {31'h0, IRQ}, 32'h0);
    rd("w1c_pend", 3'd4, 32'h0);
    check_model("A");

    // Level-mode source 7 routed to FIQ.
    wr(3'd3, 32'h00);
    wr(3'd1, 32'h80);
    wr(3'd2, 32'h80);
    IntSrc = 8'h80;
    repeat (4) step();
    chk("lvl_fiq_on", {31'h0, FIQ}, 32'h1);
    chk("lvl_irq_off", {31'h0, IRQ}, 32'h0);
    wr(3'd4, 32'h80);
    step();
    chk("lvl_fiq_w1c", {31'h0, FIQ}, 32'h1);
    rd("lvl_pend_w1c", 3'd4, 32'h80);
    IntSrc = 8'h00;
    repeat (3) step();
    chk("lvl_fiq_drop3", {31'h0, FIQ}, 32'h1);
    step();
    chk("lvl_fiq_drop4", {31'h0, FIQ}, 32'h0);
    check_model("B");

    // Edge on source 2 detected in the same cycle as its W1C.
    wr(3'd2, 32'h00);
    wr(3'd1, 32'h00);
    wr(3'd3, 32'h04);
    IntSrc = 8'h04; step();
    IntSrc = 8'h00; step();
    wr(3'd4, 32'h04);
    rd("set_wins", 3'd4, 32'h04);
    wr(3'd4, 32'h04);
    rd("w1c_after", 3'd4, 32'h00);
    check_model("C");

    // ID capture on acknowledge.
    wr(3'd3, 32'h00);
    wr(3'd2, 32'h00);
    wr(3'd1, 32'h0C);
    IntSrc = 8'h0C;
    repeat (4) step();
    rd("id_pend", 3'd4, 32'h0C);
    chk("id_irq", {31'h0, IRQ}, 32'h1);
    IRQAssert = 1'b1; step(); IRQAssert = 1'b0;
    rd("irqid", 3'd5, 32'h8000_0002);
    rd("irqid_reread", 3'd5, 32'h8000_0002);
    rd("fiqid_idle", 3'd6, 32'h0);
    wr(3'd2, 32'h08);
    IRQAssert = 1'b1; FIQAssert = 1'b1; step();
    IRQAssert = 1'b0; FIQAssert = 1'b0;
    rd("both_irqid", 3'd5, 32'h8000_0002);
    rd("both_fiqid", 3'd6, 32'h8000_0003);
    wr(3'd2, 32'h00);
    wr(3'd1, 32'h00);
    IRQAssert = 1'b1; step(); IRQAssert = 1'b0;
    rd("irqid_none", 3'd5, 32'h0);
    chk("irq_none", {31'h0, IRQ}, 32'h0);
    check_model("D");

    // Reset between clock edges while IRQ is high.
    wr(3'd1, 32'h0C);
    step();
    chk("pre_rst_irq", {31'h0, IRQ}, 32'h1);
    #2 reset = 1'b1;
    model_reset();
    #1;
    chk("mid_rst_irq", {31'h0, IRQ}, 32'h0);
    for (int a = 0; a < 8; a++) rd($sformatf("mid_rst_reg%0d", a), 3'(a), 32'h0);
    step(); step();
    reset = 1'b0;
    repeat (3) step();
    check_model("E");

    // Randomized traffic against the model.
    for (int n = 0; n < 600; n++) begin
      RegWE     = ($urandom_range(0, 3) == 0);
      RegAddr   = 3'($urandom_range(0, 7));
      RegWData  = $urandom;
      IRQAssert = ($urandom_range(0, 5) == 0);
      FIQAssert = ($urandom_range(0, 5) == 0);
      if ($urandom_range(0, 2) == 0) IntSrc = IntSrc ^ (8'($urandom) & 8'($urandom));
      #1;
      chk("rand_rd", RegRData, model_read(RegAddr));
      chk("rand_irq", {31'h0, IRQ}, {31'h0, m_irq});
      chk("rand_fiq", {31'h0, FIQ}, {31'h0, m_fiq});
      if ($urandom_range(0, 149) == 0) begin
        #2 reset = 1'b1;
        model_reset();
        #1;
        chk("rand_rst_irq", {31'h0, IRQ}, 32'h0);
        chk("rand_rst_fiq", {31'h0, FIQ}, 32'h0);
        step();
        reset = 1'b0;
      end else begin
        step();
      end
    end
    RegWE = 1'b0; IRQAssert = 1'b0; FIQAssert = 1'b0;
    check_model("F");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
